alu_result_stage: RTL

- Result-capture stage directly downstream of the datapath ALU.
- Tracks each issued ALU operation, waits the operation-dependent latency, then samples the ALU's registered Zlow/Zhigh outputs.
- Writes HI/LO for MUL/DIV and presents the 32-bit result to the bus with a valid/ready handshake.
- Gives the control unit a single busy/done view of the multi-cycle ALU.

---
 rtl/alu_result_stage.sv | 132 +++++++++++++
 1 files changed

// File: rtl/alu_result_stage.sv
// alu_result_stage: captures the multi-cycle ALU's Zlow/Zhigh after an
// op-dependent latency, updates HI/LO for MUL/DIV and presents the result
// on a valid/ready bus, giving control a single busy/done view of the ALU.
module alu_result_stage #(
  parameter int WIDTH       = 32,
  parameter int MUL_LATENCY = 1,
  parameter int DIV_LATENCY = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [3:0]       i_op,
  input  logic [WIDTH-1:0] i_zlow_in,
  input  logic [WIDTH-1:0] i_zhigh_in,
  input  logic             i_bus_ready,
  output logic             o_busy,
  output logic             o_result_valid,
  output logic [WIDTH-1:0] o_result_out,
  output logic [WIDTH-1:0] o_hi_out,
  output logic [WIDTH-1:0] o_lo_out,
  output logic             o_illegal_op
);

  localparam logic [3:0] OP_MUL = 4'b1110;
  localparam logic [3:0] OP_DIV = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_PRESENT
  } state_t;

  state_t           r_state;
  logic [7:0]       r_counter;
  logic [3:0]       r_op;
  logic             r_busy;
  logic             r_result_valid;
  logic [WIDTH-1:0] r_result_out;
  logic [WIDTH-1:0] r_hi_out;
  logic [WIDTH-1:0] r_lo_out;
  logic             r_illegal_op;

  logic [7:0]       w_latency;
  logic             w_latched_muldiv;
  logic             w_latched_illegal;

  // Latency to load into the counter for the op being issued this cycle.
  always_comb begin
    w_latency = 8'd1;
    if (i_op == OP_MUL) begin
      w_latency = 8'(MUL_LATENCY);
    end else if (i_op == OP_DIV) begin
      w_latency = 8'(DIV_LATENCY);
    end
  end

  // Classify the op latched at issue time; it decides what the capture writes.
  always_comb begin
    w_latched_muldiv  = (r_op == OP_MUL) || (r_op == OP_DIV);
    w_latched_illegal = (r_op >= 4'b1011) && (r_op <= 4'b1101);
  end

  // Issue / wait / present sequencer with all outputs registered.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= S_IDLE;
      r_counter      <= 8'd0;
      r_op           <= 4'b0000;
      r_busy         <= 1'b0;
      r_result_valid <= 1'b0;
      r_result_out   <= '0;
      r_hi_out       <= '0;
      r_lo_out       <= '0;
      r_illegal_op   <= 1'b0;
    end else begin
      r_illegal_op <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_op      <= i_op;
            r_counter <= w_latency;
            r_busy    <= 1'b1;
            r_state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_counter != 8'd0) begin
            r_counter <= r_counter - 8'd1;
          end
          if (r_counter <= 8'd1) begin
            r_result_out   <= i_zlow_in;
            r_result_valid <= 1'b1;
            r_state        <= S_PRESENT;
            if (w_latched_muldiv) begin
              r_lo_out <= i_zlow_in;
              r_hi_out <= i_zhigh_in;
            end
            if (w_latched_illegal) begin
              r_illegal_op <= 1'b1;
            end
          end
        end
        S_PRESENT: begin
          if (i_bus_ready) begin
            r_result_valid <= 1'b0;
            if (i_start) begin
              r_op      <= i_op;
              r_counter <= w_latency;
              r_state   <= S_WAIT;
            end else begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_busy         <= 1'b0;
          r_result_valid <= 1'b0;
          r_state        <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy         = r_busy;
  assign o_result_valid = r_result_valid;
  assign o_result_out   = r_result_out;
  assign o_hi_out       = r_hi_out;
  assign o_lo_out       = r_lo_out;
  assign o_illegal_op   = r_illegal_op;

endmodule
